// File: rtl/pipe_fwd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline forward/handshake controller.
//   REG_ADDR_W  : architectural register address width
//   REG_ZERO    : hard-wired zero register, never forwarded, never stalls
//   RDY_W       : storage width of a stage's result-ready index (covers 6 stages)
//   stage_tag_t : per-stage destination tag {wen, dest, rdy_stage}
//   src_live()  : true when a decode source really reads a register
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int RDY_W      = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef struct packed {
        logic             wen;
        reg_addr_t        dest;
        logic [RDY_W-1:0] rdy_stage;
    } stage_tag_t;

    // Reads of $0 are constant, so they can never depend on an in-flight write.
    function automatic logic src_live(input logic used, input reg_addr_t addr);
        return used && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipe_fwd_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_fwd_ctrl_if
// Bundles every decode-side and stage-side signal of pipe_fwd_ctrl.
//   master : the surrounding pipeline (drives DE fields, result buses, flush)
//   slave  : pipe_fwd_ctrl itself (drives stall, allowin, operands, commit)
// -----------------------------------------------------------------------------
interface pipe_fwd_ctrl_if #(
    parameter int DW     = 32,
    parameter int STAGES = 3,
    parameter int LAT_W  = 2
);
    import pipe_pkg::*;

    // decode side
    logic                   de_valid;
    reg_addr_t              de_rs;
    reg_addr_t              de_rt;
    logic                   de_rs_used;
    logic                   de_rt_used;
    logic [DW-1:0]          de_rf_rdata1;
    logic [DW-1:0]          de_rf_rdata2;
    logic                   de_wen;
    reg_addr_t              de_dest;
    logic [LAT_W-1:0]       de_rdy_stage;
    logic                   de_ready_go;
    logic                   de_allowin;
    logic [DW-1:0]          fwd_rs_data;
    logic [DW-1:0]          fwd_rt_data;

    // stage side
    logic [STAGES*DW-1:0]   stage_res_data;
    logic [STAGES-1:0]      stage_ready_go;
    logic                   flush;
    logic [STAGES-1:0]      stage_valid;
    logic [STAGES-1:0]      stage_allowin;
    logic                   commit_valid;
    reg_addr_t              commit_dest;

    modport master (
        output de_valid, de_rs, de_rt, de_rs_used, de_rt_used,
               de_rf_rdata1, de_rf_rdata2, de_wen, de_dest, de_rdy_stage,
               stage_res_data, stage_ready_go, flush,
        input  de_ready_go, de_allowin, fwd_rs_data, fwd_rt_data,
               stage_valid, stage_allowin, commit_valid, commit_dest
    );

    modport slave (
        input  de_valid, de_rs, de_rt, de_rs_used, de_rt_used,
               de_rf_rdata1, de_rf_rdata2, de_wen, de_dest, de_rdy_stage,
               stage_res_data, stage_ready_go, flush,
        output de_ready_go, de_allowin, fwd_rs_data, fwd_rt_data,
               stage_valid, stage_allowin, commit_valid, commit_dest
    );

endinterface

// File: rtl/pipe_fwd_ctrl_stage_slot.sv
// -----------------------------------------------------------------------------
// stage_slot
// One pipeline stage's valid bit and destination tag.
//   clk, reset : clock, asynchronous active-high reset
//   load       : stage allowin; capture in_valid/in_tag this edge
//   kill       : flush hits this stage; valid clears regardless of load
//   in_valid   : instruction arriving from the younger neighbour (or DE)
//   in_tag     : tag travelling with it
//   valid, tag : registered contents
// -----------------------------------------------------------------------------
module stage_slot
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       kill,
    input  logic       in_valid,
    input  stage_tag_t in_tag,
    output logic       valid,
    output stage_tag_t tag
);

    logic       valid_q, valid_d;
    stage_tag_t tag_q, tag_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so a path
        // that assigns nothing holds the register instead of inferring a latch.
        valid_d = valid_q;
        tag_d   = tag_q;
        if (load) begin
            // Tags follow even when the incoming slot is a bubble; they are
            // only ever consulted together with valid.
            valid_d = in_valid;
            tag_d   = in_tag;
        end
        if (kill) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: tags are reset along with valid so commit/forward outputs
            // are fully defined straight out of reset, not only masked by valid.
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            // NOTE: non-blocking so every slot samples its neighbour's old
            // contents on the same edge and the shift behaves as a pipeline.
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign valid = valid_q;
    assign tag   = tag_q;

endmodule

// File: rtl/pipe_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_fwd_ctrl
// Pipeline control between decode and the EXE..WB stage registers: tracks a
// valid bit and destination tag per stage, builds the allowin chain, resolves
// RAW hazards by forwarding from the youngest matching stage or stalling DE,
// and reports the retiring instruction.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pipe_fwd_ctrl_if.slave (DE fields, result buses, flush in;
//                de_ready_go/de_allowin, operands, stage valid/allowin and
//                commit out)
// Parameters: DW data width, STAGES tracked stages (2..6), LAT_W width of the
// result-ready index, FLUSH_STAGES youngest stages killed by flush (0..STAGES).
// -----------------------------------------------------------------------------
module pipe_fwd_ctrl
    import pipe_pkg::*;
#(
    parameter int DW           = 32,
    parameter int STAGES       = 3,
    parameter int LAT_W        = 2,
    parameter int FLUSH_STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    pipe_fwd_ctrl_if.slave  bus
);

    logic              slot_valid [STAGES];
    stage_tag_t        slot_tag   [STAGES];
    logic              in_valid   [STAGES];
    stage_tag_t        in_tag     [STAGES];
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] allowin;
    logic              de_ready_go;

    // ---------------------------------------------------------------- slots
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign in_valid[g] = bus.de_valid & de_ready_go & ~bus.flush;
            assign in_tag[g]   = '{wen:       bus.de_wen,
                                   dest:      bus.de_dest,
                                   rdy_stage: RDY_W'(bus.de_rdy_stage)};
        end else begin : g_body
            assign in_valid[g] = slot_valid[g-1] & bus.stage_ready_go[g-1];
            assign in_tag[g]   = slot_tag[g-1];
        end

        stage_slot u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (allowin[g]),
            .kill     (bus.flush && (g < FLUSH_STAGES)),
            .in_valid (in_valid[g]),
            .in_tag   (in_tag[g]),
            .valid    (slot_valid[g]),
            .tag      (slot_tag[g])
        );
    end

    // --------------------------------------------------------- allowin chain
    // Walk from WB (which always retires) back to EXE so each stage sees the
    // allowin of the stage ahead of it.
    always_comb begin
        logic nxt;
        valid   = '0;
        allowin = '0;
        nxt     = 1'b1;
        for (int i = STAGES - 1; i >= 0; i--) begin
            valid[i]   = slot_valid[i];
            allowin[i] = !slot_valid[i] || (bus.stage_ready_go[i] && nxt);
            nxt        = allowin[i];
        end
    end

    // --------------------------------------------------------- hazard search
    logic          rs_hit, rs_ok, rs_stall;
    logic          rt_hit, rt_ok, rt_stall;
    logic [DW-1:0] rs_hit_data, rt_hit_data;
    logic [DW-1:0] rs_data, rt_data;

    always_comb begin
        rs_hit      = 1'b0;
        rs_ok       = 1'b0;
        rs_hit_data = '0;
        rt_hit      = 1'b0;
        rt_ok       = 1'b0;
        rt_hit_data = '0;
        // Scan oldest to youngest; the last match written is the youngest
        // producer, which holds the architecturally newest value.
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (slot_valid[i] && slot_tag[i].wen && slot_tag[i].dest == bus.de_rs) begin
                rs_hit      = 1'b1;
                rs_ok       = (i >= int'(slot_tag[i].rdy_stage));
                rs_hit_data = bus.stage_res_data[i*DW +: DW];
            end
            if (slot_valid[i] && slot_tag[i].wen && slot_tag[i].dest == bus.de_rt) begin
                rt_hit      = 1'b1;
                rt_ok       = (i >= int'(slot_tag[i].rdy_stage));
                rt_hit_data = bus.stage_res_data[i*DW +: DW];
            end
        end

        rs_data  = bus.de_rf_rdata1;
        rs_stall = 1'b0;
        if (src_live(bus.de_rs_used, bus.de_rs) && rs_hit) begin
            if (rs_ok) rs_data  = rs_hit_data;
            else       rs_stall = 1'b1;
        end

        rt_data  = bus.de_rf_rdata2;
        rt_stall = 1'b0;
        if (src_live(bus.de_rt_used, bus.de_rt) && rt_hit) begin
            if (rt_ok) rt_data  = rt_hit_data;
            else       rt_stall = 1'b1;
        end

        de_ready_go = !(rs_stall || rt_stall);
    end

    // -------------------------------------------------------------- outputs
    assign bus.de_ready_go   = de_ready_go;
    assign bus.de_allowin    = !bus.de_valid || (de_ready_go && allowin[0]);
    assign bus.fwd_rs_data   = rs_data;
    assign bus.fwd_rt_data   = rt_data;
    assign bus.stage_valid   = valid;
    assign bus.stage_allowin = allowin;
    assign bus.commit_valid  = valid[STAGES-1] & bus.stage_ready_go[STAGES-1];
    // A bubble in WB still carries stale tags, so qualify with commit_valid.
    assign bus.commit_dest   = (bus.commit_valid && slot_tag[STAGES-1].wen)
                             ? slot_tag[STAGES-1].dest : REG_ZERO;

endmodule

// File: tb/tb_pipe_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_fwd_ctrl
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural pipeline model kept in this bench.
// -----------------------------------------------------------------------------
module tb_pipe_fwd_ctrl;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int S  = 3;
    localparam int LW = 2;
    localparam int FS = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_fwd_ctrl_if #(.DW(DW), .STAGES(S), .LAT_W(LW)) bus ();

    pipe_fwd_ctrl #(.DW(DW), .STAGES(S), .LAT_W(LW), .FLUSH_STAGES(FS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------------------------------------------- reference model
    bit            m_v [S];
    bit            m_w [S];
    logic [4:0]    m_d [S];
    int            m_r [S];

    bit            e_rg, e_dealw, e_cv;
    bit            e_alw [S];
    logic [DW-1:0] e_rs, e_rt;
    logic [4:0]    e_cd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void resolve(input bit used, input logic [4:0] src,
                                    input logic [DW-1:0] rf,
                                    output bit stall, output logic [DW-1:0] data);
        stall = 1'b0;
        data  = rf;
        if (used && src != 5'd0) begin
            for (int i = 0; i < S; i++) begin
                if (m_v[i] && m_w[i] && m_d[i] == src) begin
                    if (i >= m_r[i]) data  = bus.stage_res_data[i*DW +: DW];
                    else             stall = 1'b1;
                    break;
                end
            end
        end
    endfunction

    task automatic model_expect();
        bit s1, s2, nxt;
        resolve(bus.de_rs_used, bus.de_rs, bus.de_rf_rdata1, s1, e_rs);
        resolve(bus.de_rt_used, bus.de_rt, bus.de_rf_rdata2, s2, e_rt);
        e_rg = !(s1 || s2);
        nxt  = 1'b1;
        for (int i = S - 1; i >= 0; i--) begin
            e_alw[i] = !m_v[i] || (bus.stage_ready_go[i] && nxt);
            nxt      = e_alw[i];
        end
        e_dealw = !bus.de_valid || (e_rg && e_alw[0]);
        e_cv    = m_v[S-1] && bus.stage_ready_go[S-1];
        e_cd    = (e_cv && m_w[S-1]) ? m_d[S-1] : 5'd0;
    endtask

    task automatic model_edge();
        for (int i = S - 1; i >= 1; i--) begin
            if (e_alw[i]) begin
                m_v[i] = m_v[i-1] && bus.stage_ready_go[i-1];
                m_w[i] = m_w[i-1];
                m_d[i] = m_d[i-1];
                m_r[i] = m_r[i-1];
            end
        end
        if (e_alw[0]) begin
            m_v[0] = bus.de_valid && e_rg && !bus.flush;
            m_w[0] = bus.de_wen;
            m_d[0] = bus.de_dest;
            m_r[0] = int'(bus.de_rdy_stage);
        end
        if (bus.flush) for (int i = 0; i < FS; i++) m_v[i] = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            m_v[i] = 1'b0; m_w[i] = 1'b0; m_d[i] = 5'd0; m_r[i] = 0;
        end
    endtask

    task automatic check_all();
        logic [S-1:0] ev, ea;
        for (int i = 0; i < S; i++) begin
            ev[i] = m_v[i];
            ea[i] = e_alw[i];
        end
        check("de_ready_go",   64'(bus.de_ready_go),   64'(e_rg));
        check("de_allowin",    64'(bus.de_allowin),    64'(e_dealw));
        check("fwd_rs_data",   64'(bus.fwd_rs_data),   64'(e_rs));
        check("fwd_rt_data",   64'(bus.fwd_rt_data),   64'(e_rt));
        check("stage_valid",   64'(bus.stage_valid),   64'(ev));
        check("stage_allowin", 64'(bus.stage_allowin), 64'(ea));
        check("commit_valid",  64'(bus.commit_valid),  64'(e_cv));
        if (e_cv) check("commit_dest", 64'(bus.commit_dest), 64'(e_cd));
    endtask

    // One cycle: settle, compare against the model, clock, advance the model.
    task automatic step();
        #1;
        model_expect();
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_de(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                          input bit ru, input bit tu, input bit wen,
                          input logic [4:0] dest, input logic [LW-1:0] rdy);
        bus.de_valid     = v;
        bus.de_rs        = rs;
        bus.de_rt        = rt;
        bus.de_rs_used   = ru;
        bus.de_rt_used   = tu;
        bus.de_wen       = wen;
        bus.de_dest      = dest;
        bus.de_rdy_stage = rdy;
    endtask

    task automatic idle(input int n);
        set_de(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, '0);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_res(input int i, input logic [DW-1:0] val);
        bus.stage_res_data[i*DW +: DW] = val;
    endtask

    // --------------------------------------------------------- stimulus
    initial begin
        reset = 1'b1;
        set_de(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, '0);
        bus.de_rf_rdata1   = '0;
        bus.de_rf_rdata2   = '0;
        bus.stage_res_data = '0;
        bus.stage_ready_go = '1;
        bus.flush          = 1'b0;
        model_reset();

        // reset state
        @(negedge clk);
        #1;
        check("rst_stage_valid",   64'(bus.stage_valid),   64'(3'b000));
        check("rst_stage_allowin", 64'(bus.stage_allowin), 64'(3'b111));
        check("rst_commit_valid",  64'(bus.commit_valid),  64'(0));
        check("rst_commit_dest",   64'(bus.commit_dest),   64'(0));
        check("rst_de_ready_go",   64'(bus.de_ready_go),   64'(1));
        reset = 1'b0;
        idle(2);

        // 1: ALU back-to-back forwards from EXE with no stall
        bus.de_rf_rdata1 = 32'h11; bus.de_rf_rdata2 = 32'h22;
        set_de(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 2'd0);
        step();
        set_de(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 2'd0);
        set_res(0, 32'h0000_0005);
        #1;
        check("alu_fwd_rs", 64'(bus.fwd_rs_data), 64'(32'h0000_0005));
        check("alu_no_stall", 64'(bus.de_ready_go), 64'(1));
        step();

        // 2: load-use stalls exactly one cycle, then forwards from MEM
        idle(3);
        set_de(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 2'd1);
        step();
        set_de(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 2'd0);
        set_res(0, 32'h0000_1234);
        set_res(1, 32'hDEAD_BEEF);
        #1;
        check("lu_stall", 64'(bus.de_ready_go), 64'(0));
        check("lu_de_allowin", 64'(bus.de_allowin), 64'(0));
        step();
        #1;
        check("lu_resume", 64'(bus.de_ready_go), 64'(1));
        check("lu_fwd_rs", 64'(bus.fwd_rs_data), 64'(32'hDEAD_BEEF));
        check("lu_bubble", 64'(bus.stage_valid[0]), 64'(0));
        step();

        // 3: register zero is never forwarded and never stalls
        idle(3);
        set_de(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 2'd1);
        step();
        bus.de_rf_rdata1 = 32'h0;
        set_res(0, 32'hFFFF_FFFF);
        set_de(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 2'd0);
        #1;
        check("r0_no_stall", 64'(bus.de_ready_go), 64'(1));
        check("r0_fwd_rs", 64'(bus.fwd_rs_data), 64'(0));
        step();

        // 4: MEM held by a multi-cycle unit for three cycles
        idle(3);
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 2'd0); step();
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 2'd0); step();
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 2'd0); step();
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 2'd0);
        bus.stage_ready_go[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_allowin0", 64'(bus.stage_allowin[0]), 64'(0));
            check("hold_de_allowin", 64'(bus.de_allowin), 64'(0));
            check("hold_mem_exe_valid", 64'(bus.stage_valid[1:0]), 64'(2'b11));
            step();
        end
        bus.stage_ready_go[1] = 1'b1;
        step();
        #1;
        check("rel_commit_valid", 64'(bus.commit_valid), 64'(1));
        check("rel_commit_dest", 64'(bus.commit_dest), 64'(8));
        step();

        // 5: flush kills EXE, MEM advances to WB, DE does not enter
        idle(3);
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 2'd0); step();
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12, 2'd0); step();
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13, 2'd0);
        bus.flush = 1'b1;
        bus.stage_ready_go[0] = 1'b0;
        step();
        bus.flush = 1'b0;
        bus.stage_ready_go[0] = 1'b1;
        set_de(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, '0);
        #1;
        check("fl_exe_killed", 64'(bus.stage_valid[0]), 64'(0));
        check("fl_wb_valid", 64'(bus.stage_valid[2]), 64'(1));
        check("fl_commit_dest", 64'(bus.commit_dest), 64'(11));
        step();

        // 6: asynchronous reset between edges with the pipe full
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd20, 2'd0); step();
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd21, 2'd0); step();
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd22, 2'd0); step();
        #2;
        reset = 1'b1;
        #1;
        check("ar_stage_valid", 64'(bus.stage_valid), 64'(3'b000));
        check("ar_commit_valid", 64'(bus.commit_valid), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_de(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd14, 2'd0);
        step();
        #1;
        check("ar_first_issue", 64'(bus.stage_valid), 64'(3'b001));
        idle(1);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            set_de(1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   LW'($urandom_range(0, 2)));
            bus.de_rf_rdata1   = $urandom;
            bus.de_rf_rdata2   = $urandom;
            bus.stage_res_data = {$urandom, $urandom, $urandom};
            for (int i = 0; i < S; i++) bus.stage_ready_go[i] = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
